// File: rtl/muldiv_seq_ctrl_if.sv
// Pipeline-side handshake bundle for the multiply/divide sequencer.
// The slave modport is the sequencer; the master modport is the pipeline/divider side.
interface muldiv_seq_ctrl_if;
  logic i_flush;
  logic i_mult_req;
  logic i_div_req;
  logic i_divisor_zero;
  logic i_MEM_stall;
  logic i_div_done;
  logic o_div_start;
  logic o_div_abort;
  logic o_EXE_stall;
  logic o_EXE_MEM_ena;
  logic o_EXE_MEM_bubble;
  logic o_busy;
  logic o_div_timeout;

  modport slave (
    input  i_flush, i_mult_req, i_div_req, i_divisor_zero, i_MEM_stall, i_div_done,
    output o_div_start, o_div_abort, o_EXE_stall, o_EXE_MEM_ena, o_EXE_MEM_bubble,
           o_busy, o_div_timeout
  );

  modport master (
    output i_flush, i_mult_req, i_div_req, i_divisor_zero, i_MEM_stall, i_div_done,
    input  o_div_start, o_div_abort, o_EXE_stall, o_EXE_MEM_ena, o_EXE_MEM_bubble,
           o_busy, o_div_timeout
  );
endinterface

// File: rtl/muldiv_seq_ctrl.sv
// Sequencer for the multi-cycle MULT/DIV units feeding the EXE/MEM register.
// Optional macro MULDIV_DIV0_FAST_EN: divide-by-zero skips the divider and completes after one stall cycle.
module muldiv_seq_ctrl #(
  parameter int unsigned MULT_LATENCY = 3,
  parameter int unsigned DIV_TIMEOUT  = 40
) (
  input logic              clk,
  input logic              reset,
  muldiv_seq_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [7:0] MULT_LOAD = 8'(MULT_LATENCY - 1);
  localparam logic [7:0] DIV_LOAD  = 8'(DIV_TIMEOUT - 1);

  state_t     state;
  logic [7:0] count;
  logic       busy_q;
  logic       timeout_q;

  logic       accept_div;
  logic       accept_mult;
  logic       div0_fast;
  logic       div_expire;
  logic       exe_stall;
  logic [7:0] count_dec;

  // Request acceptance is only possible from IDLE and never during a flush; DIV beats MULT.
  always_comb begin
    accept_div  = (state == IDLE) & bus.i_div_req & ~bus.i_flush;
    accept_mult = (state == IDLE) & bus.i_mult_req & ~bus.i_div_req & ~bus.i_flush;
    div_expire  = (state == DIV) & (count == 8'd0) & ~bus.i_div_done & ~bus.i_flush;
    count_dec   = (count == 8'd0) ? 8'd0 : count - 8'd1;
  end

`ifdef MULDIV_DIV0_FAST_EN
  assign div0_fast = accept_div & bus.i_divisor_zero;
`else
  logic unused_divisor_zero;
  assign unused_divisor_zero = bus.i_divisor_zero;
  assign div0_fast           = 1'b0;
`endif

  // The multiplier leaves MULT as its counter reaches zero; the divider is given
  // the full counter range including the zero cycle before it is declared timed out.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      count     <= 8'd0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else if (bus.i_flush) begin
      state  <= IDLE;
      count  <= 8'd0;
      busy_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (div0_fast) begin
            state     <= DONE;
            count     <= 8'd0;
            busy_q    <= 1'b1;
            timeout_q <= 1'b0;
          end else if (accept_div) begin
            state     <= DIV;
            count     <= DIV_LOAD;
            busy_q    <= 1'b1;
            timeout_q <= 1'b0;
          end else if (accept_mult) begin
            state     <= (MULT_LATENCY <= 1) ? DONE : MULT;
            count     <= MULT_LOAD;
            busy_q    <= 1'b1;
            timeout_q <= 1'b0;
          end
        end
        MULT: begin
          count <= count_dec;
          if (count <= 8'd1) begin
            state <= DONE;
          end
        end
        DIV: begin
          count <= count_dec;
          if (bus.i_div_done) begin
            state <= DONE;
          end else if (count == 8'd0) begin
            state     <= DONE;
            timeout_q <= 1'b1;
          end
        end
        DONE: begin
          if (!bus.i_MEM_stall) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        end
      endcase
    end
  end

  // Stall starts combinationally on the request cycle so EXE never slips past an unaccepted op.
  assign exe_stall = ~reset & ~bus.i_flush &
                     (((state == IDLE) & (bus.i_mult_req | bus.i_div_req)) |
                      (state == MULT) | (state == DIV));

  assign bus.o_div_start      = ~reset & accept_div & ~div0_fast;
  assign bus.o_div_abort      = ~reset & (state == DIV) & (bus.i_flush | div_expire);
  assign bus.o_EXE_stall      = exe_stall;
  assign bus.o_EXE_MEM_ena    = reset | ~bus.i_MEM_stall;
  assign bus.o_EXE_MEM_bubble = exe_stall & ~bus.i_MEM_stall;
  assign bus.o_busy           = busy_q;
  assign bus.o_div_timeout    = timeout_q;

endmodule

// File: tb/tb_muldiv_seq_ctrl.sv
// Directed bench for muldiv_seq_ctrl with MULT_LATENCY=3, DIV_TIMEOUT=40.
// Honours MULDIV_DIV0_FAST_EN for the divide-by-zero expectations.
module tb_muldiv_seq_ctrl;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  muldiv_seq_ctrl_if bus();

  muldiv_seq_ctrl #(
    .MULT_LATENCY(3),
    .DIV_TIMEOUT (40)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // Drive all inputs for the current cycle, then let combinational outputs settle.
  task automatic applyStimulus(input logic flush, input logic mult, input logic div,
                               input logic dz, input logic mstall, input logic done);
    bus.i_flush        = flush;
    bus.i_mult_req     = mult;
    bus.i_div_req      = div;
    bus.i_divisor_zero = dz;
    bus.i_MEM_stall    = mstall;
    bus.i_div_done     = done;
    #1;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int starts;
    int stalls;
    int aborts;
    int first_done;
    int abort_at;

    applyStimulus(0, 0, 0, 0, 0, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput("reset busy",    bus.o_busy, 0);
    checkOutput("reset stall",   bus.o_EXE_stall, 0);
    checkOutput("reset bubble",  bus.o_EXE_MEM_bubble, 0);
    checkOutput("reset ena",     bus.o_EXE_MEM_ena, 1);
    checkOutput("reset start",   bus.o_div_start, 0);
    checkOutput("reset abort",   bus.o_div_abort, 0);
    checkOutput("reset timeout", bus.o_div_timeout, 0);
    reset = 1'b0;
    nextCycle();

    $display("[TB] multiply latency sequence");
    for (int c = 0; c <= 4; c++) begin
      applyStimulus(0, c <= 3, 0, 0, 0, 0);
      checkOutput($sformatf("mult stall c%0d", c),  bus.o_EXE_stall, c <= 2);
      checkOutput($sformatf("mult bubble c%0d", c), bus.o_EXE_MEM_bubble, c <= 2);
      checkOutput($sformatf("mult busy c%0d", c),   bus.o_busy, (c >= 1) && (c <= 3));
      nextCycle();
    end

    $display("[TB] multiply with downstream stall");
    for (int c = 0; c <= 4; c++) begin
      applyStimulus(0, c <= 3, 0, 0, c == 1, 0);
      if (c == 1) begin
        checkOutput("mult mstall stall",  bus.o_EXE_stall, 1);
        checkOutput("mult mstall bubble", bus.o_EXE_MEM_bubble, 0);
        checkOutput("mult mstall ena",    bus.o_EXE_MEM_ena, 0);
      end
      if (c == 4) checkOutput("mult mstall idle", bus.o_busy, 0);
      nextCycle();
    end

    $display("[TB] divide completing at cycle 33");
    starts = 0; stalls = 0; aborts = 0;
    for (int c = 0; c <= 35; c++) begin
      applyStimulus(0, 0, c <= 34, 0, 0, c == 33);
      if (c == 0) checkOutput("div start c0", bus.o_div_start, 1);
      starts += int'(bus.o_div_start);
      stalls += int'(bus.o_EXE_stall);
      aborts += int'(bus.o_div_abort);
      if (c == 34) begin
        checkOutput("div done busy",    bus.o_busy, 1);
        checkOutput("div done stall",   bus.o_EXE_stall, 0);
        checkOutput("div done timeout", bus.o_div_timeout, 0);
      end
      if (c == 35) checkOutput("div idle", bus.o_busy, 0);
      nextCycle();
    end
    checkOutput("div start count", starts, 1);
    checkOutput("div stall count", stalls, 34);
    checkOutput("div abort count", aborts, 0);

    $display("[TB] divide timeout");
    aborts = 0; first_done = -1; abort_at = -1;
    for (int c = 0; c <= 42; c++) begin
      applyStimulus(0, 0, c <= 41, 0, 0, 0);
      if (bus.o_div_abort === 1'b1) begin
        aborts++;
        abort_at = c;
      end
      if (first_done < 0 && bus.o_busy === 1'b1 && bus.o_EXE_stall === 1'b0) first_done = c;
      if (c == 41) checkOutput("tmo flag in done", bus.o_div_timeout, 1);
      if (c == 42) begin
        checkOutput("tmo idle",   bus.o_busy, 0);
        checkOutput("tmo sticky", bus.o_div_timeout, 1);
      end
      nextCycle();
    end
    checkOutput("tmo done cycle",  first_done, 41);
    checkOutput("tmo abort count", aborts, 1);
    checkOutput("tmo abort cycle", abort_at, 40);

    $display("[TB] flush during divide");
    for (int c = 0; c <= 6; c++) begin
      applyStimulus(c == 5, 0, c <= 5, 0, 0, 0);
      if (c == 1) checkOutput("flush tmo cleared", bus.o_div_timeout, 0);
      if (c == 4) checkOutput("flush no early abort", bus.o_div_abort, 0);
      if (c == 5) begin
        checkOutput("flush abort",  bus.o_div_abort, 1);
        checkOutput("flush stall",  bus.o_EXE_stall, 0);
        checkOutput("flush bubble", bus.o_EXE_MEM_bubble, 0);
      end
      if (c == 6) begin
        checkOutput("flush idle",       bus.o_busy, 0);
        checkOutput("flush abort once", bus.o_div_abort, 0);
      end
      nextCycle();
    end

    applyStimulus(1, 0, 1, 0, 0, 0);
    checkOutput("flush idle start", bus.o_div_start, 0);
    checkOutput("flush idle stall", bus.o_EXE_stall, 0);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("flush idle not accepted", bus.o_busy, 0);
    nextCycle();

    $display("[TB] DONE held by downstream stall");
    starts = 0;
    for (int c = 0; c <= 6; c++) begin
      applyStimulus(0, 0, c <= 5, 0, (c == 3) || (c == 4), c == 2);
      starts += int'(bus.o_div_start);
      if (c == 3 || c == 4) begin
        checkOutput($sformatf("hold ena c%0d", c),   bus.o_EXE_MEM_ena, 0);
        checkOutput($sformatf("hold busy c%0d", c),  bus.o_busy, 1);
        checkOutput($sformatf("hold stall c%0d", c), bus.o_EXE_stall, 0);
      end
      if (c == 5) begin
        checkOutput("hold release ena",  bus.o_EXE_MEM_ena, 1);
        checkOutput("hold release busy", bus.o_busy, 1);
      end
      if (c == 6) checkOutput("hold idle", bus.o_busy, 0);
      nextCycle();
    end
    checkOutput("hold single start", starts, 1);

    $display("[TB] simultaneous requests");
    for (int c = 0; c <= 3; c++) begin
      applyStimulus(0, c <= 2, c <= 2, 0, 0, c == 1);
      if (c == 0) checkOutput("both start", bus.o_div_start, 1);
      if (c == 2) begin
        checkOutput("both done busy",  bus.o_busy, 1);
        checkOutput("both done stall", bus.o_EXE_stall, 0);
      end
      if (c == 3) checkOutput("both idle", bus.o_busy, 0);
      nextCycle();
    end

    $display("[TB] divide by zero");
`ifdef MULDIV_DIV0_FAST_EN
    for (int c = 0; c <= 2; c++) begin
      applyStimulus(0, 0, c <= 1, 1, 0, 0);
      if (c == 0) begin
        checkOutput("div0 fast stall", bus.o_EXE_stall, 1);
        checkOutput("div0 fast start", bus.o_div_start, 0);
      end
      if (c == 1) begin
        checkOutput("div0 fast done busy",  bus.o_busy, 1);
        checkOutput("div0 fast done stall", bus.o_EXE_stall, 0);
      end
      if (c == 2) checkOutput("div0 fast idle", bus.o_busy, 0);
      nextCycle();
    end
`else
    for (int c = 0; c <= 3; c++) begin
      applyStimulus(0, 0, c <= 2, 1, 0, c == 1);
      if (c == 0) begin
        checkOutput("div0 stall", bus.o_EXE_stall, 1);
        checkOutput("div0 start", bus.o_div_start, 1);
      end
      if (c == 1) checkOutput("div0 still stalled", bus.o_EXE_stall, 1);
      if (c == 2) begin
        checkOutput("div0 done busy",  bus.o_busy, 1);
        checkOutput("div0 done stall", bus.o_EXE_stall, 0);
      end
      if (c == 3) checkOutput("div0 idle", bus.o_busy, 0);
      nextCycle();
    end
`endif

    $display("[TB] reset mid-divide");
    applyStimulus(0, 0, 1, 0, 0, 0);
    nextCycle();
    nextCycle();
    nextCycle();
    checkOutput("pre-reset busy", bus.o_busy, 1);
    reset = 1'b1;
    #1;
    checkOutput("midreset busy",  bus.o_busy, 0);
    checkOutput("midreset stall", bus.o_EXE_stall, 0);
    checkOutput("midreset abort", bus.o_div_abort, 0);
    checkOutput("midreset start", bus.o_div_start, 0);
    checkOutput("midreset ena",   bus.o_EXE_MEM_ena, 1);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    nextCycle();
    checkOutput("post-reset idle", bus.o_busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
